// File: rtl/xor_bind_pkg.sv
// ============================================================================
// Module  : xor_bind_pkg
// Purpose : Shared types and helpers for the XOR-relation bind monitor.
//           - xb_state_e : monitor FSM state encoding (exported on 'state')
//           - LAT_MAX    : deepest supported a/b -> c latency
//           - chw()      : width of a channel index, never narrower than 1 bit
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package xor_bind_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } xb_state_e;

  localparam int LAT_MAX = 16;

  // A single channel still needs a 1-bit index port.
  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/xor_bind_delay.sv
// ============================================================================
// Module  : xor_bind_delay
// Purpose : Valid-tagged data shift line of LAT stages. Valid bits clear on
//           async reset or synchronous flush; LAT=0 is a pure passthrough.
// Ports   : clk      - rising-edge clock
//           rst      - asynchronous active-high reset
//           flush_i  - synchronous clear of every in-flight valid bit
//           vld_i    - sample valid entering the line
//           data_i   - sample data entering the line
//           vld_o    - valid at the tail of the line
//           data_o   - data at the tail of the line
//           busy_o   - any valid sample still inside the line
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_bind_delay
  import xor_bind_pkg::*;
#(
  parameter int DW  = 8,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          vld_i,
  input  logic [DW-1:0] data_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o,
  output logic          busy_o
);

  // Latencies outside 0..LAT_MAX are clamped into the supported range.
  localparam int c_DEPTH = (LAT > LAT_MAX) ? LAT_MAX : ((LAT < 0) ? 0 : LAT);

  if (c_DEPTH == 0) begin : g_pass
    // Same-cycle compare: nothing is ever in flight.
    logic w_unused;
    assign w_unused = ^{clk, rst, flush_i};
    assign vld_o    = vld_i;
    assign data_o   = data_i;
    assign busy_o   = 1'b0;
  end else begin : g_line
    logic [c_DEPTH-1:0] vld_q;
    logic [DW-1:0]      data_q [c_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        for (int k = 0; k < c_DEPTH; k++) begin
          data_q[k] <= '0;
        end
      end else begin
        vld_q[0]  <= vld_i & ~flush_i;
        data_q[0] <= data_i;
        for (int k = 1; k < c_DEPTH; k++) begin
          vld_q[k]  <= vld_q[k-1] & ~flush_i;
          data_q[k] <= data_q[k-1];
        end
      end
    end

    assign vld_o  = vld_q[c_DEPTH-1];
    assign data_o = data_q[c_DEPTH-1];
    assign busy_o = |vld_q;
  end

endmodule

`default_nettype wire

// File: rtl/xor_bind_monitor.sv
// ============================================================================
// Module  : xor_bind_monitor
// Purpose : Multi-channel pipelined checker of c[i] == a[i]^b[i], with c
//           arriving LAT cycles after a/b. Keeps sticky error flags,
//           saturating per-channel mismatch counters and a first-failure
//           capture; optionally freezes everything after the first mismatch.
//           Port names match the observed DUT so it can be bound with (.*).
// Ports   : clk       - rising-edge clock
//           rst       - asynchronous active-high reset
//           en        - accept new samples
//           clr       - synchronous clear of all bookkeeping and pipeline
//           valid     - a/b carry a sample this cycle
//           a, b      - operands, channel i at [i*W +: W]
//           c         - DUT result, same packing, LAT cycles after a/b
//           err_any   - sticky any-mismatch flag
//           err_mask  - sticky per-channel mismatch flags
//           err_cnt   - per-channel saturating counts, channel i at [i*CW +: CW]
//           first_vld - first-failure capture valid
//           first_ch  - lowest failing channel of the first failing compare
//           first_exp - expected value at first failure
//           first_obs - observed c at first failure
//           state     - FSM state (xb_state_e)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_bind_monitor
  import xor_bind_pkg::*;
#(
  parameter  int W           = 8,
  parameter  int NCH         = 4,
  parameter  int LAT         = 1,
  parameter  int CW          = 8,
  parameter  int HALT_ON_ERR = 0,
  localparam int CHW         = chw(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              valid,
  input  logic [NCH*W-1:0]  a,
  input  logic [NCH*W-1:0]  b,
  input  logic [NCH*W-1:0]  c,
  output logic              err_any,
  output logic [NCH-1:0]    err_mask,
  output logic [NCH*CW-1:0] err_cnt,
  output logic              first_vld,
  output logic [CHW-1:0]    first_ch,
  output logic [W-1:0]      first_exp,
  output logic [W-1:0]      first_obs,
  output logic [1:0]        state
);

  localparam logic [CW-1:0] c_CNT_MAX = '1;

  xb_state_e                state_q, state_d;
  logic                     err_any_q, err_any_d;
  logic [NCH-1:0]           err_mask_q, err_mask_d;
  logic [NCH-1:0][CW-1:0]   cnt_q, cnt_d;
  logic                     first_vld_q, first_vld_d;
  logic [CHW-1:0]           first_ch_q, first_ch_d;
  logic [W-1:0]             first_exp_q, first_exp_d;
  logic [W-1:0]             first_obs_q, first_obs_d;

  logic                     w_accept;
  logic                     w_pipe_vld;
  logic [NCH*W-1:0]         w_pipe_exp;
  logic                     w_busy;
  logic [NCH-1:0]           w_mis;
  logic                     w_err_evt;

  // Expected result is formed at accept time so only NCH*W bits travel.
  assign w_accept = en && valid && (state_q != HALT);

  xor_bind_delay #(
    .DW  (NCH*W),
    .LAT (LAT)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .flush_i (clr),
    .vld_i   (w_accept),
    .data_i  (a ^ b),
    .vld_o   (w_pipe_vld),
    .data_o  (w_pipe_exp),
    .busy_o  (w_busy)
  );

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_mis[g] = w_pipe_vld && (c[g*W +: W] != w_pipe_exp[g*W +: W]);
  end

  // Compares that land while halted are ignored.
  assign w_err_evt = (|w_mis) && (state_q != HALT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = CHECK;
      CHECK:   if (!en && !w_busy) state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    // A same-cycle LAT=0 compare can fail before IDLE has moved to CHECK,
    // so halting is taken from any non-halted state.
    if (w_err_evt && (HALT_ON_ERR != 0)) state_d = HALT;
    if (clr) state_d = IDLE;
  end

  always_comb begin
    err_any_d   = err_any_q;
    err_mask_d  = err_mask_q;
    cnt_d       = cnt_q;
    first_vld_d = first_vld_q;
    first_ch_d  = first_ch_q;
    first_exp_d = first_exp_q;
    first_obs_d = first_obs_q;
    if (clr) begin
      err_any_d   = 1'b0;
      err_mask_d  = '0;
      cnt_d       = '0;
      first_vld_d = 1'b0;
      first_ch_d  = '0;
      first_exp_d = '0;
      first_obs_d = '0;
    end else if (w_err_evt) begin
      err_any_d  = 1'b1;
      err_mask_d = err_mask_q | w_mis;
      for (int i = 0; i < NCH; i++) begin
        if (w_mis[i] && (cnt_q[i] != c_CNT_MAX)) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      if (!first_vld_q) begin
        first_vld_d = 1'b1;
        // Walk downwards so the lowest failing channel is the one kept.
        for (int i = NCH - 1; i >= 0; i--) begin
          if (w_mis[i]) begin
            first_ch_d  = CHW'(i);
            first_exp_d = w_pipe_exp[i*W +: W];
            first_obs_d = c[i*W +: W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      err_any_q   <= 1'b0;
      err_mask_q  <= '0;
      cnt_q       <= '0;
      first_vld_q <= 1'b0;
      first_ch_q  <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else begin
      state_q     <= state_d;
      err_any_q   <= err_any_d;
      err_mask_q  <= err_mask_d;
      cnt_q       <= cnt_d;
      first_vld_q <= first_vld_d;
      first_ch_q  <= first_ch_d;
      first_exp_q <= first_exp_d;
      first_obs_q <= first_obs_d;
    end
  end

  assign err_any   = err_any_q;
  assign err_mask  = err_mask_q;
  assign err_cnt   = cnt_q;
  assign first_vld = first_vld_q;
  assign first_ch  = first_ch_q;
  assign first_exp = first_exp_q;
  assign first_obs = first_obs_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_xor_bind_monitor.sv
// ============================================================================
// Module  : tb_xor_bind_monitor
// Purpose : Directed self-checking bench for xor_bind_monitor. Five monitors
//           share one a/b stream; each sees c delayed to match its latency,
//           with per-sample corruption travelling alongside the sample.
//             u0 LAT=1 CW=8          u1 LAT=1 CW=2 (saturation)
//             u2 LAT=1 HALT_ON_ERR=1 u3 LAT=0      u4 LAT=3
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_bind_monitor;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        en    = 1'b0;
  logic        clr   = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [31:0] bad   = '0;
  logic [31:0] hist1 = '0;
  logic [31:0] hist2 = '0;
  logic [31:0] hist3 = '0;
  logic [31:0] c_l0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign c_l0 = a ^ b ^ bad;
  always @(posedge clk) begin
    hist1 <= a ^ b ^ bad;
    hist2 <= hist1;
    hist3 <= hist2;
  end

  logic       ea0, ea1, ea2, ea3, ea4;
  logic [3:0] em0, em1, em2, em3, em4;
  logic [31:0] ec0, ec2, ec3, ec4;
  logic [7:0]  ec1;
  logic       fv0, fv1, fv2, fv3, fv4;
  logic [1:0] fc0, fc1, fc2, fc3, fc4;
  logic [7:0] fe0, fe1, fe2, fe3, fe4;
  logic [7:0] fo0, fo1, fo2, fo3, fo4;
  logic [1:0] st0, st1, st2, st3, st4;

  xor_bind_monitor #(.W(8), .NCH(4), .LAT(1), .CW(8), .HALT_ON_ERR(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid), .a(a), .b(b), .c(hist1),
    .err_any(ea0), .err_mask(em0), .err_cnt(ec0), .first_vld(fv0), .first_ch(fc0),
    .first_exp(fe0), .first_obs(fo0), .state(st0));

  xor_bind_monitor #(.W(8), .NCH(4), .LAT(1), .CW(2), .HALT_ON_ERR(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid), .a(a), .b(b), .c(hist1),
    .err_any(ea1), .err_mask(em1), .err_cnt(ec1), .first_vld(fv1), .first_ch(fc1),
    .first_exp(fe1), .first_obs(fo1), .state(st1));

  xor_bind_monitor #(.W(8), .NCH(4), .LAT(1), .CW(8), .HALT_ON_ERR(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid), .a(a), .b(b), .c(hist1),
    .err_any(ea2), .err_mask(em2), .err_cnt(ec2), .first_vld(fv2), .first_ch(fc2),
    .first_exp(fe2), .first_obs(fo2), .state(st2));

  xor_bind_monitor #(.W(8), .NCH(4), .LAT(0), .CW(8), .HALT_ON_ERR(0)) u3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid), .a(a), .b(b), .c(c_l0),
    .err_any(ea3), .err_mask(em3), .err_cnt(ec3), .first_vld(fv3), .first_ch(fc3),
    .first_exp(fe3), .first_obs(fo3), .state(st3));

  xor_bind_monitor #(.W(8), .NCH(4), .LAT(3), .CW(8), .HALT_ON_ERR(0)) u4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid), .a(a), .b(b), .c(hist3),
    .err_any(ea4), .err_mask(em4), .err_cnt(ec4), .first_vld(fv4), .first_ch(fc4),
    .first_exp(fe4), .first_obs(fo4), .state(st4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] badv);
    @(negedge clk);
    a     = av;
    b     = bv;
    bad   = badv;
    valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      bad   = '0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    valid = 1'b0;
    bad   = '0;
    clr   = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_err_any", ea0, 0);
    chk("rst_err_mask", em0, 0);
    chk("rst_err_cnt", ec0, 0);
    chk("rst_first_vld", fv0, 0);
    chk("rst_state", st0, 0);
    chk("rst_state_lat3", st4, 0);

    en = 1'b1;
    idle(1);
    chk("state_check", st0, 1);

    // Clean random traffic, full throughput
    for (int i = 0; i < 20; i++) drive($urandom, $urandom, 32'h0);
    idle(5);
    chk("clean_err_any_l1", ea0, 0);
    chk("clean_err_cnt_l1", ec0, 0);
    chk("clean_first_vld", fv0, 0);
    chk("clean_err_any_l0", ea3, 0);
    chk("clean_err_any_l3", ea4, 0);
    chk("clean_state_halt_inst", st2, 1);

    // Single ch2 corruption in bit0: expected 0x2D, observed 0x2C
    drive(32'h11223344, 32'h0F0F0F0F, 32'h0001_0000);
    idle(5);
    chk("ch2_err_any", ea0, 1);
    chk("ch2_err_mask", em0, 4'b0100);
    chk("ch2_err_cnt", ec0, 32'h0001_0000);
    chk("ch2_first_vld", fv0, 1);
    chk("ch2_first_ch", fc0, 2);
    chk("ch2_first_exp", fe0, 8'h2D);
    chk("ch2_first_obs", fo0, 8'h2C);
    chk("ch2_mask_l0", em3, 4'b0100);
    chk("ch2_obs_l0", fo3, 8'h2C);
    chk("ch2_mask_l3", em4, 4'b0100);
    chk("ch2_obs_l3", fo4, 8'h2C);
    chk("ch2_halt_state", st2, 2);

    // clr clears everything and releases HALT
    pulse_clr();
    chk("clr_err_any", ea0, 0);
    chk("clr_err_cnt", ec0, 0);
    chk("clr_first_vld", fv0, 0);
    chk("clr_halt_to_idle", st2, 0);

    // ch1 and ch3 fail together, then a later ch0 failure
    drive(32'hA5A5A5A5, 32'h3C3C3C3C, 32'h0100_0100);
    idle(2);
    chk("dual_first_ch", fc0, 1);
    chk("dual_first_exp", fe0, 8'h99);
    chk("dual_first_obs", fo0, 8'h98);
    chk("dual_err_cnt", ec0, 32'h0100_0100);
    drive(32'h0, 32'h0, 32'h0000_0080);
    idle(5);
    chk("later_err_mask", em0, 4'b1011);
    chk("later_err_cnt", ec0, 32'h0100_0101);
    chk("later_first_ch", fc0, 1);
    chk("later_first_obs", fo0, 8'h98);
    chk("later_first_ch_l3", fc4, 1);

    // ch0 fails five times: CW=2 saturates at 3, CW=8 counts 5, HALT keeps 1
    pulse_clr();
    repeat (5) drive(32'h12345678, 32'h0, 32'h1);
    idle(5);
    chk("sat_cnt_cw2", ec1, 8'h03);
    chk("sat_mask_cw2", em1, 4'b0001);
    chk("sat_cnt_cw8", ec0, 32'h5);
    chk("halt_state", st2, 2);
    chk("halt_cnt", ec2, 32'h1);
    chk("halt_first_vld", fv2, 1);
    pulse_clr();
    chk("halt_clr_state", st2, 0);
    chk("halt_clr_err_any", ea2, 0);
    chk("halt_clr_cnt", ec2, 0);
    chk("halt_clr_first_vld", fv2, 0);

    // en dropped with a sample in flight: it is still checked, then drains to IDLE
    drive(32'h0, 32'h0, 32'h0100_0000);
    @(negedge clk);
    en    = 1'b0;
    valid = 1'b0;
    bad   = '0;
    idle(5);
    chk("endrop_mask_l3", em4, 4'b1000);
    chk("endrop_state_l3", st4, 0);
    // valid while en is low is not accepted
    drive(32'h0, 32'h0, 32'h0000_0001);
    idle(5);
    chk("en_low_mask_l0", em3, 4'b1000);
    chk("en_low_mask_l3", em4, 4'b1000);
    en = 1'b1;

    // rst mid-stream discards in-flight samples
    pulse_clr();
    drive(32'h0, 32'h0, 32'h0000_0002);
    drive(32'h0, 32'h0, 32'h0000_0002);
    @(negedge clk);
    valid = 1'b0;
    bad   = '0;
    chk("pre_rst_err_any_l0", ea3, 1);
    chk("pre_rst_err_any_l1", ea0, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_err_any_l0", ea3, 0);
    chk("async_rst_err_any_l1", ea0, 0);
    chk("async_rst_first_vld_l1", fv0, 0);
    chk("async_rst_state_l1", st0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    chk("post_rst_err_any_l3", ea4, 0);
    chk("post_rst_err_cnt_l3", ec4, 0);
    chk("post_rst_first_vld_l3", fv4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
